merge_sort_stream: RTL and testbench
====================================

# merge_sort_stream

Parametrised streaming successor to the 8x4 merge sorter. Accepts blocks of `GROUPS` beats of four signed samples, sorts each beat with the 4-input sorting network, and stores it as a sorted run. A `GROUPS`-way merge then emits the block one element per cycle. Two ping-pong banks let one block fill while the previous one drains. Per-block ascending/descending mode, backpressure and end-of-block marking are added. The block sits between the sample front-end and the downstream rank/statistics logic.

## Interface

**Parameters**
- `DATA_W`, default 8: sample width in bits, signed two's complement, range 2..32.
- `GROUPS`, default 8: beats per block, a power of two in 2..16. Block size `N = 4*GROUPS`.

**Ports**
- `clk`  in  1  single clock, rising edge; all state is updated on the rising edge only.
- `rst`  in  1  asynchronous, active-low reset.
- `BlkIn`  in  1  start-of-block marker; qualified by `InValid`.
- `InValid`  in  1  beat valid.
- `InReady`  out  1  beat accepted on an edge where `InValid && InReady`.
- `In1`, `In2`, `In3`, `In4`  in  `DATA_W`  signed samples of the beat.
- `Descend`  in  1  order for the block, sampled on the beat carrying `BlkIn`.
- `SortOut`  out  `DATA_W`  signed sorted element.
- `OutValid`  out  1  `SortOut` valid. There is no output stall.
- `OutLast`  out  1  marks the N-th element of a block.
- `BlkErr`  out  1  sticky error; set when a partial block is discarded.

## Operation

**Reset values:** `SortOut=0`, `OutValid=0`, `OutLast=0`, `BlkErr=0`, `InReady=1`. Both banks are marked empty, and beat counters and run head pointers are cleared. Reset mid-block abandons all data without producing any output.

**Fill FSM (per fill bank):** states IDLE → FILL → FULL.
- IDLE:
  - An accepted beat with `BlkIn=1` stores run 0, latches `Descend`, sets beat count to 1 and enters FILL.
  - An accepted beat with `BlkIn=0` is dropped silently.
- FILL:
  - An accepted beat with `BlkIn=0` stores run[count] and increments the count.
  - When beat `GROUPS-1` is stored, the FSM enters FULL.
  - An accepted beat with `BlkIn=1` discards the partial block, sets `BlkErr`, and restarts as beat 0 of a new block.
- FULL: the bank waits for the drain side to become idle. Then the banks swap, the fill side returns to IDLE, and the filled bank starts draining.

**Run storage:** each beat is sorted combinationally by the 4-sort network before it is written. Within a run, entry 0 is the extreme value for the latched order: the maximum when descending, the minimum when ascending.

**Drain FSM:** states IDLE → MERGE.
- Each MERGE cycle considers the head of every non-exhausted run and selects the maximum (descending) or minimum (ascending).
- Comparison is signed. On a tie, the lowest run index wins.
- The selected run's head pointer increments. A pointer is `clog2(4)+1` bits, and the run is exhausted when the pointer reaches 4.
- An exhausted run is excluded from selection. It is never treated as a sentinel value, so -2^(DATA_W-1) and 2^(DATA_W-1)-1 sort correctly.
- A down-counter from N-1 sets `OutLast` when it reaches 0. The FSM then returns to IDLE, or to MERGE directly if the other bank is FULL (swap on the same edge).

**InReady:** `InReady = !(fill bank FULL)`, driven from registered state only.

**Simultaneous events:** the last beat of a fill and the last element of a drain on the same edge cause the swap on that edge. Output continues with no bubble.

## Timing

- Fill takes `GROUPS` accepted beats. The swap happens on the edge that accepts the last beat when the drain side is idle.
- First `OutValid` is seen after the edge following the swap, so input-last-beat to first output is 1 cycle.
- A block drains in exactly N consecutive cycles with `OutValid=1`. `OutLast` is high only on the final one.
- With back-to-back blocks at default parameters: `InReady` drops after beat 8 of the second block and rises on the edge that emits `OutLast` of the first block. Sustained throughput is 1 element/cycle.
- `BlkErr` rises after the offending edge and holds until `rst`.

## Configuration

- `MERGE_SORT_ORDER_SEL_EN`
  - Defined: `Descend` is latched per block and selects the order as described above.
  - Undefined: `Descend` is ignored and the order is fixed descending. The compare-direction logic is removed and the port remains unconnected internally.

## Test plan

- **Reset and single block:** `GROUPS=8`, beats (8,7,6,5)…(-20,-21,-22,-23), `Descend=0` → 32 `OutValid` cycles ascending from -23 to 8, `OutLast` on the 32nd, first output 1 cycle after the last beat.
- **Extremes and ties:** all lanes `-128` except one `127`, plus duplicated values across runs → 127 first when descending, every -128 emitted, count exactly 32, no element lost or repeated.
- **Back-to-back blocks:** continuous `InValid` → `InReady` low from after beat 16 until block 1 `OutLast`, block 2 output contiguous with block 1 (no gap cycle).
- **Protocol error:** `BlkIn` reasserted on beat 3 → `BlkErr=1`, the first 3 beats are never output, and the new block sorts correctly. Beats with `BlkIn=0` while IDLE → no output.
- **Async reset mid-drain:** `rst` low at element 10 → `OutValid` and `SortOut` go to 0 immediately and `InReady=1`. The next block is sorted correctly.
- **Parameter sweep:** `DATA_W=12`, `GROUPS=2` and `16` with random data and random `Descend` → output matches the scoreboard sort for every block.

Source files
------------

// File: rtl/merge_sort_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | merge_sort_stream: ping-pong block sorter, 4-sort per beat + GROUPS-way    |
// | merge, one element per cycle. Option macro: MERGE_SORT_ORDER_SEL_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module merge_sort_stream #(
  parameter int DATA_W = 8,
  parameter int GROUPS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     BlkIn,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic signed [DATA_W-1:0] In1,
  input  logic signed [DATA_W-1:0] In2,
  input  logic signed [DATA_W-1:0] In3,
  input  logic signed [DATA_W-1:0] In4,
  input  logic                     Descend,
  output logic signed [DATA_W-1:0] SortOut,
  output logic                     OutValid,
  output logic                     OutLast,
  output logic                     BlkErr
);

  localparam int N      = 4 * GROUPS;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int OCNT_W = $clog2(N);
  localparam int PTR_W  = $clog2(4) + 1;

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_FILL  = 2'd1;
  localparam logic [1:0] F_FULL  = 2'd2;
  localparam logic [0:0] D_IDLE  = 1'b0;
  localparam logic [0:0] D_MERGE = 1'b1;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(GROUPS - 1);
  localparam logic [OCNT_W-1:0] LAST_ELEM = OCNT_W'(N - 1);

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t smin(input sample_t x, input sample_t y);
    return (x < y) ? x : y;
  endfunction

  function automatic sample_t smax(input sample_t x, input sample_t y);
    return (x > y) ? x : y;
  endfunction

  sample_t mem_q [2][GROUPS][4];

  logic [1:0]        fstate_q, fstate_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              fbank_q, fbank_d;
  logic [0:0]        dstate_q, dstate_d;
  logic [PTR_W-1:0]  ptr_q [GROUPS];
  logic [PTR_W-1:0]  ptr_d [GROUPS];
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  sample_t           sort_q, sort_d;
  logic              ovalid_q, ovalid_d;
  logic              olast_q, olast_d;
  logic              err_q, err_d;

  logic              wdesc;
  sample_t           b0, b1, b2, b3, c0, c1, c2, c3;
  sample_t           srt   [4];
  sample_t           store [4];
  logic              wr_en;
  logic [CNT_W-1:0]  wr_run;
  logic              accept, fill_done, full_now, drain_free;
  logic              sel_found, take;
  logic [CNT_W-1:0]  sel_idx;
  sample_t           sel_val, head;

`ifdef MERGE_SORT_ORDER_SEL_EN
  logic fdesc_q, fdesc_d, ddesc_q, ddesc_d;
  // A beat that opens a block carries its own order; later beats use the latch.
  assign wdesc = (fstate_q == F_IDLE || BlkIn) ? Descend : fdesc_q;
`else
  logic unused_descend;
  assign unused_descend = Descend;
  assign wdesc          = 1'b1;
`endif

  assign InReady  = (fstate_q != F_FULL);
  assign SortOut  = sort_q;
  assign OutValid = ovalid_q;
  assign OutLast  = olast_q;
  assign BlkErr   = err_q;

  always_comb begin
    b0 = smin(In1, In2);
    b1 = smax(In1, In2);
    b2 = smin(In3, In4);
    b3 = smax(In3, In4);
    c0 = smin(b0, b2);
    c2 = smax(b0, b2);
    c1 = smin(b1, b3);
    c3 = smax(b1, b3);
    srt[0] = c0;
    srt[1] = smin(c1, c2);
    srt[2] = smax(c1, c2);
    srt[3] = c3;
    for (int k = 0; k < 4; k++) begin
      store[k] = wdesc ? srt[3-k] : srt[k];
    end
  end

  always_comb begin
    fstate_d  = fstate_q;
    fcnt_d    = fcnt_q;
    fbank_d   = fbank_q;
    dstate_d  = dstate_q;
    ocnt_d    = ocnt_q;
    sort_d    = sort_q;
    ovalid_d  = 1'b0;
    olast_d   = 1'b0;
    err_d     = err_q;
    wr_en     = 1'b0;
    wr_run    = fcnt_q;
    fill_done = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_val   = '0;
    head      = '0;
    take      = 1'b0;
    for (int r = 0; r < GROUPS; r++) begin
      ptr_d[r] = ptr_q[r];
    end
`ifdef MERGE_SORT_ORDER_SEL_EN
    fdesc_d = fdesc_q;
    ddesc_d = ddesc_q;
`endif
    accept = InValid && InReady;

    case (fstate_q)
      F_IDLE: begin
        if (accept && BlkIn) begin
          wr_en    = 1'b1;
          wr_run   = '0;
          fcnt_d   = CNT_W'(1);
          fstate_d = F_FILL;
`ifdef MERGE_SORT_ORDER_SEL_EN
          fdesc_d  = Descend;
`endif
        end
      end
      F_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (BlkIn) begin
            err_d  = 1'b1;
            wr_run = '0;
            fcnt_d = CNT_W'(1);
`ifdef MERGE_SORT_ORDER_SEL_EN
            fdesc_d = Descend;
`endif
          end else if (fcnt_q == LAST_BEAT) begin
            fill_done = 1'b1;
          end else begin
            fcnt_d = fcnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Exhausted runs are skipped outright so extreme sample values need no sentinel.
    for (int r = 0; r < GROUPS; r++) begin
      head = mem_q[~fbank_q][r][ptr_q[r][1:0]];
`ifdef MERGE_SORT_ORDER_SEL_EN
      take = ddesc_q ? (head > sel_val) : (head < sel_val);
`else
      take = (head > sel_val);
`endif
      if (!ptr_q[r][PTR_W-1] && (!sel_found || take)) begin
        sel_found = 1'b1;
        sel_idx   = CNT_W'(r);
        sel_val   = head;
      end
    end

    if (dstate_q == D_MERGE) begin
      ovalid_d         = 1'b1;
      sort_d           = sel_val;
      olast_d          = (ocnt_q == '0);
      ptr_d[sel_idx]   = ptr_q[sel_idx] + PTR_W'(1);
      if (ocnt_q == '0) begin
        dstate_d = D_IDLE;
      end else begin
        ocnt_d = ocnt_q - OCNT_W'(1);
      end
    end

    drain_free = (dstate_q == D_IDLE) || (ocnt_q == '0);
    full_now   = fill_done || (fstate_q == F_FULL);

    if (full_now && drain_free) begin
      fbank_d  = ~fbank_q;
      fstate_d = F_IDLE;
      fcnt_d   = '0;
      dstate_d = D_MERGE;
      ocnt_d   = LAST_ELEM;
      for (int r = 0; r < GROUPS; r++) begin
        ptr_d[r] = '0;
      end
`ifdef MERGE_SORT_ORDER_SEL_EN
      ddesc_d = fdesc_q;
`endif
    end else if (fill_done) begin
      fstate_d = F_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fstate_q <= F_IDLE;
      fcnt_q   <= '0;
      fbank_q  <= 1'b0;
      dstate_q <= D_IDLE;
      ocnt_q   <= '0;
      sort_q   <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int r = 0; r < GROUPS; r++) begin
        ptr_q[r] <= '0;
      end
`ifdef MERGE_SORT_ORDER_SEL_EN
      fdesc_q <= 1'b0;
      ddesc_q <= 1'b0;
`endif
    end else begin
      fstate_q <= fstate_d;
      fcnt_q   <= fcnt_d;
      fbank_q  <= fbank_d;
      dstate_q <= dstate_d;
      ocnt_q   <= ocnt_d;
      sort_q   <= sort_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      err_q    <= err_d;
      for (int r = 0; r < GROUPS; r++) begin
        ptr_q[r] <= ptr_d[r];
      end
`ifdef MERGE_SORT_ORDER_SEL_EN
      fdesc_q <= fdesc_d;
      ddesc_q <= ddesc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[fbank_q][wr_run][k] <= store[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_merge_sort_stream.sv
`default_nettype none
// Directed bench for merge_sort_stream: 8x8 instance plus a 12-bit, 2-group instance.
module tb_merge_sort_stream;

`ifdef MERGE_SORT_ORDER_SEL_EN
  localparam bit SEL = 1'b1;
`else
  localparam bit SEL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              BlkIn = 1'b0, InValid = 1'b0, Descend = 1'b0;
  logic signed [7:0] In1 = '0, In2 = '0, In3 = '0, In4 = '0;
  logic              InReady, OutValid, OutLast, BlkErr;
  logic signed [7:0] SortOut;

  logic               blk2 = 1'b0, val2 = 1'b0, desc2 = 1'b0;
  logic signed [11:0] a2 = '0, b2 = '0, c2 = '0, d2 = '0;
  logic               rdy2, ov2, ol2, err2;
  logic signed [11:0] so2;

  merge_sort_stream #(.DATA_W(8), .GROUPS(8)) u_dut (
    .clk(clk), .rst(rst), .BlkIn(BlkIn), .InValid(InValid), .InReady(InReady),
    .In1(In1), .In2(In2), .In3(In3), .In4(In4), .Descend(Descend),
    .SortOut(SortOut), .OutValid(OutValid), .OutLast(OutLast), .BlkErr(BlkErr)
  );

  merge_sort_stream #(.DATA_W(12), .GROUPS(2)) u_dut2 (
    .clk(clk), .rst(rst), .BlkIn(blk2), .InValid(val2), .InReady(rdy2),
    .In1(a2), .In2(b2), .In3(c2), .In4(d2), .Descend(desc2),
    .SortOut(so2), .OutValid(ov2), .OutLast(ol2), .BlkErr(err2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int q_val[$];
  int q_cyc[$];
  bit q_last[$];
  int q2_val[$];
  bit q2_last[$];
  int exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (OutValid) begin
      q_val.push_back(int'(SortOut));
      q_last.push_back(OutLast);
      q_cyc.push_back(cyc);
    end
    if (ov2) begin
      q2_val.push_back(int'(so2));
      q2_last.push_back(ol2);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic blk, input logic d, input int v0, input int v1,
                      input int v2, input int v3);
    int g = 0;
    BlkIn = blk; Descend = d; InValid = 1'b1;
    In1 = v0[7:0]; In2 = v1[7:0]; In3 = v2[7:0]; In4 = v3[7:0];
    while (!InReady && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("send_ready_timeout", int'(InReady), 1);
    @(negedge clk);
  endtask

  task automatic idle();
    InValid = 1'b0;
    BlkIn   = 1'b0;
  endtask

  task automatic clear_q();
    q_val.delete();
    q_cyc.delete();
    q_last.delete();
  endtask

  task automatic check_stream(input string tag, input int exp[$], input int blk,
                              input int first_cyc);
    int g = 0;
    int n;
    while (q_val.size() < exp.size() && g < exp.size() + 60) begin
      @(negedge clk);
      g++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, q_val.size(), exp.size());
    n = (q_val.size() < exp.size()) ? q_val.size() : exp.size();
    if (n > 0 && first_cyc >= 0) check({tag, "_latency"}, q_cyc[0], first_cyc);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_val[%0d]", tag, i), q_val[i], exp[i]);
      check($sformatf("%s_last[%0d]", tag, i), int'(q_last[i]), (i % blk == blk - 1) ? 1 : 0);
      if (i > 0) check($sformatf("%s_gap[%0d]", tag, i), q_cyc[i], q_cyc[i-1] + 1);
    end
  endtask

  int t2 [8][4] = '{
    '{-128, -128,  127, -128},
    '{-128, -128, -128, -128},
    '{-128, -128, -128, -128},
    '{-128, -128, -128, -128},
    '{   5,    5,    5, -128},
    '{   5,    0,    0,   -1},
    '{-128, -128, -128, -128},
    '{ 127, -128,    0,    5}
  };

  initial begin
    int last_cyc;
    int rise_cyc;
    int g;

    // Reset state
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outvalid", int'(OutValid), 0);
    check("rst_outlast", int'(OutLast), 0);
    check("rst_blkerr", int'(BlkErr), 0);
    check("rst_inready", int'(InReady), 1);
    check("rst_sortout", int'(SortOut), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single block, ascending requested (descending when order select is absent)
    for (int k = 0; k < 8; k++) send(k == 0, 1'b0, 8-4*k, 7-4*k, 6-4*k, 5-4*k);
    last_cyc = cyc;
    idle();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(SEL ? (-23 + i) : (8 - i));
    check_stream("single", exp_q, 32, last_cyc + 1);
    clear_q();

    // Extremes and ties, descending
    for (int k = 0; k < 8; k++) send(k == 0, 1'b1, t2[k][0], t2[k][1], t2[k][2], t2[k][3]);
    idle();
    exp_q.delete();
    repeat (2)  exp_q.push_back(127);
    repeat (5)  exp_q.push_back(5);
    repeat (3)  exp_q.push_back(0);
    exp_q.push_back(-1);
    repeat (21) exp_q.push_back(-128);
    check_stream("extreme", exp_q, 32, -1);
    clear_q();

    // Back-to-back blocks with continuous InValid
    for (int k = 0; k < 8; k++) send(k == 0, 1'b1, k, k+8, k+16, k+24);
    for (int k = 0; k < 8; k++) send(k == 0, 1'b1, -(k+1), -(k+9), -(k+17), -(k+25));
    idle();
    check("b2b_ready_low", int'(InReady), 0);
    g = 0;
    while (!InReady && g < 100) begin
      @(negedge clk);
      g++;
    end
    rise_cyc = cyc;
    check("b2b_ready_rise", int'(InReady), 1);
    exp_q.delete();
    for (int i = 31; i >= 0; i--) exp_q.push_back(i);
    for (int i = 1; i <= 32; i++) exp_q.push_back(-i);
    check_stream("b2b", exp_q, 32, -1);
    if (q_cyc.size() >= 32) check("b2b_rise_at_last", rise_cyc, q_cyc[31]);
    clear_q();

    // Protocol error: stray beats while idle, then BlkIn reasserted on beat 3
    send(1'b0, 1'b1, 50, 51, 52, 53);
    send(1'b0, 1'b1, 54, 55, 56, 57);
    idle();
    repeat (10) @(negedge clk);
    check("stray_no_output", q_val.size(), 0);
    check("stray_no_err", int'(BlkErr), 0);
    send(1'b1, 1'b1, 100, 101, 102, 103);
    send(1'b0, 1'b1, 104, 105, 106, 107);
    send(1'b0, 1'b1, 108, 109, 110, 111);
    for (int k = 0; k < 8; k++) send(k == 0, 1'b1, 10*k-3, 10*k-1, 10*k+2, 10*k);
    idle();
    check("err_set", int'(BlkErr), 1);
    exp_q.delete();
    for (int k = 7; k >= 0; k--) begin
      exp_q.push_back(10*k+2);
      exp_q.push_back(10*k);
      exp_q.push_back(10*k-1);
      exp_q.push_back(10*k-3);
    end
    check_stream("err", exp_q, 32, -1);
    check("err_sticky", int'(BlkErr), 1);
    clear_q();

    // Narrow-block instance: DATA_W=12, GROUPS=2
    check("p2_ready", int'(rdy2), 1);
    blk2 = 1'b1; val2 = 1'b1; desc2 = 1'b1;
    a2 = -12'sd2048; b2 = 12'sd2047; c2 = 12'sd0; d2 = -12'sd1;
    @(negedge clk);
    blk2 = 1'b0;
    a2 = 12'sd2047; b2 = 12'sd5; c2 = -12'sd2048; d2 = 12'sd100;
    @(negedge clk);
    val2 = 1'b0;
    repeat (20) @(negedge clk);
    exp_q = '{2047, 2047, 100, 5, 0, -1, -2048, -2048};
    check("p2_count", q2_val.size(), 8);
    for (int i = 0; i < 8 && i < q2_val.size(); i++) begin
      check($sformatf("p2_val[%0d]", i), q2_val[i], exp_q[i]);
      check($sformatf("p2_last[%0d]", i), int'(q2_last[i]), (i == 7) ? 1 : 0);
    end

    // Asynchronous reset in the middle of a drain
    for (int k = 0; k < 8; k++) send(k == 0, 1'b1, 8-4*k, 7-4*k, 6-4*k, 5-4*k);
    idle();
    g = 0;
    while (q_val.size() < 10 && g < 60) begin
      @(negedge clk);
      g++;
    end
    #2 rst = 1'b0;
    #1;
    check("arst_outvalid", int'(OutValid), 0);
    check("arst_sortout", int'(SortOut), 0);
    check("arst_inready", int'(InReady), 1);
    check("arst_blkerr", int'(BlkErr), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_q();
    repeat (45) @(negedge clk);
    check("arst_abandoned", q_val.size(), 0);
    for (int k = 0; k < 8; k++) send(k == 0, 1'b0, 8-4*k, 7-4*k, 6-4*k, 5-4*k);
    last_cyc = cyc;
    idle();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(SEL ? (-23 + i) : (8 - i));
    check_stream("post_rst", exp_q, 32, last_cyc + 1);
    clear_q();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
